// File: rtl/frac_clk_pkg.sv
`default_nettype none
// ============================================================================
// Module  : frac_clk_pkg
// Brief   : Shared channel state encoding and ratio record for frac_clk_gen.
// Revision: 1.0 - initial release
// ============================================================================
package frac_clk_pkg;

    localparam int c_RATIO_MAX_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_PEND = 2'd2
    } chState_t;

    typedef struct packed {
        logic [c_RATIO_MAX_W-1:0] num;
        logic [c_RATIO_MAX_W-1:0] den;
    } ratio_t;

    // A usable ratio is a non-zero fraction no greater than one.
    function automatic logic ratioLegal(input ratio_t r);
        return (r.num != '0) && (r.den != '0) && (r.num <= r.den);
    endfunction

endpackage
`default_nettype wire

// File: rtl/frac_clk_ch.sv
`default_nettype none
// ============================================================================
// Module  : frac_clk_ch
// Brief   : One fractional-N channel: phase accumulator, tick/clock outputs
//           and the IDLE/RUN/PEND ratio-update state machine.
// Revision: 1.0 - initial release
// ============================================================================
module frac_clk_ch
    import frac_clk_pkg::*;
#(
    parameter int DEN_W   = 16,
    parameter int RST_NUM = 10,
    parameter int RST_DEN = 12
) (
    input  logic             clkIn,
    input  logic             reset,
    input  logic             en,
    input  logic             cfgStb,
    input  logic [DEN_W-1:0] cfgNum,
    input  logic [DEN_W-1:0] cfgDen,
    output logic             busy,
    output logic             tick,
    output logic             clkOut
);

    chState_t         r_state,   w_state;
    logic [DEN_W-1:0] r_num,     w_num;
    logic [DEN_W-1:0] r_den,     w_den;
    logic [DEN_W-1:0] r_pendNum, w_pendNum;
    logic [DEN_W-1:0] r_pendDen, w_pendDen;
    logic [DEN_W:0]   r_acc,     w_acc;
    logic             r_tick,    w_tick;
    logic             r_clkOut,  w_clkOut;
    logic             r_idleAck, w_idleAck;

    logic [DEN_W:0]   w_sum;
    logic             w_wrap;
    logic [DEN_W:0]   w_accStep;

    assign w_sum     = r_acc + {1'b0, r_num};
    assign w_wrap    = (w_sum >= {1'b0, r_den});
    assign w_accStep = w_wrap ? (w_sum - {1'b0, r_den}) : w_sum;

    always_ff @(posedge clkIn or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_num     <= DEN_W'(RST_NUM);
            r_den     <= DEN_W'(RST_DEN);
            r_pendNum <= '0;
            r_pendDen <= '0;
            r_acc     <= '0;
            r_tick    <= 1'b0;
            r_clkOut  <= 1'b0;
            r_idleAck <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_num     <= w_num;
            r_den     <= w_den;
            r_pendNum <= w_pendNum;
            r_pendDen <= w_pendDen;
            r_acc     <= w_acc;
            r_tick    <= w_tick;
            r_clkOut  <= w_clkOut;
            r_idleAck <= w_idleAck;
        end
    end

    always_comb begin
        w_state   = r_state;
        w_num     = r_num;
        w_den     = r_den;
        w_pendNum = r_pendNum;
        w_pendDen = r_pendDen;
        w_acc     = r_acc;
        w_tick    = 1'b0;
        w_idleAck = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_acc = '0;
                if (cfgStb) begin
                    w_num     = cfgNum;
                    w_den     = cfgDen;
                    w_idleAck = 1'b1;
                end
                if (en) begin
                    w_state = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!en) begin
                    // An update landing on the disable edge is applied directly.
                    w_state = ST_IDLE;
                    w_acc   = '0;
                    if (cfgStb) begin
                        w_num     = cfgNum;
                        w_den     = cfgDen;
                        w_idleAck = 1'b1;
                    end
                end else begin
                    w_acc  = w_accStep;
                    w_tick = w_wrap;
                    if (cfgStb) begin
                        w_pendNum = cfgNum;
                        w_pendDen = cfgDen;
                        w_state   = ST_PEND;
                    end
                end
            end
            ST_PEND: begin
                if (!en) begin
                    w_num   = r_pendNum;
                    w_den   = r_pendDen;
                    w_acc   = '0;
                    w_state = ST_IDLE;
                end else begin
                    w_acc  = w_accStep;
                    w_tick = w_wrap;
                    if (w_wrap) begin
                        w_num   = r_pendNum;
                        w_den   = r_pendDen;
                        w_acc   = '0;
                        w_state = ST_RUN;
                    end
                end
            end
            default: begin
                w_state = ST_IDLE;
                w_acc   = '0;
            end
        endcase

        w_clkOut = r_clkOut ^ w_tick;
    end

    assign busy   = (r_state == ST_PEND) || r_idleAck;
    assign tick   = r_tick;
    assign clkOut = r_clkOut;

endmodule
`default_nettype wire

// File: rtl/frac_clk_gen.sv
`default_nettype none
// ============================================================================
// Module  : frac_clk_gen
// Brief   : Multi-channel fractional clock-enable generator with a shared,
//           validated ratio-update port.
// Revision: 1.0 - initial release
// ============================================================================
module frac_clk_gen
    import frac_clk_pkg::*;
#(
    parameter  int NUM_CH   = 2,
    parameter  int DEN_W    = 16,
    parameter  int FREQ_IN  = 12,
    parameter  int FREQ_OUT = 10,
    localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clkIn,
    input  logic              reset,
    input  logic [NUM_CH-1:0] en,
    input  logic              cfgValid,
    output logic              cfgReady,
    input  logic [CH_W-1:0]   cfgCh,
    input  logic [DEN_W-1:0]  cfgNum,
    input  logic [DEN_W-1:0]  cfgDen,
    output logic              cfgErr,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] clkOut
);

    if ((FREQ_OUT > FREQ_IN) || (FREQ_OUT == 0)) begin : g_badFreq
        $error("frac_clk_gen: FREQ_OUT must be non-zero and not exceed FREQ_IN");
    end
    if ((DEN_W < 1) || (DEN_W >= c_RATIO_MAX_W) || (NUM_CH < 1)) begin : g_badShape
        $error("frac_clk_gen: unsupported DEN_W or NUM_CH");
    end
    if (longint'(FREQ_IN) >= (64'd1 << DEN_W)) begin : g_badWidth
        $error("frac_clk_gen: FREQ_IN does not fit in DEN_W bits");
    end

    ratio_t            w_cfg;
    logic              w_chOk;
    logic              w_xfer;
    logic              w_accept;
    logic [NUM_CH-1:0] w_stb;
    logic [NUM_CH-1:0] w_busy;
    logic              r_cfgErr;

    assign w_cfg.num = c_RATIO_MAX_W'(cfgNum);
    assign w_cfg.den = c_RATIO_MAX_W'(cfgDen);
    assign w_chOk    = (32'(cfgCh) < 32'(NUM_CH));
    assign w_xfer    = cfgValid && cfgReady;
    assign w_accept  = w_xfer && w_chOk && ratioLegal(w_cfg);

    always_ff @(posedge clkIn or posedge reset) begin
        if (reset) begin
            r_cfgErr <= 1'b0;
        end else begin
            r_cfgErr <= w_xfer && !w_accept;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign w_stb[i] = w_accept && (cfgCh == CH_W'(i));

        frac_clk_ch #(
            .DEN_W   (DEN_W),
            .RST_NUM (FREQ_OUT),
            .RST_DEN (FREQ_IN)
        ) u_ch (
            .clkIn  (clkIn),
            .reset  (reset),
            .en     (en[i]),
            .cfgStb (w_stb[i]),
            .cfgNum (cfgNum),
            .cfgDen (cfgDen),
            .busy   (w_busy[i]),
            .tick   (tick[i]),
            .clkOut (clkOut[i])
        );
    end

    // A single update slot is shared by all channels.
    assign cfgReady = ~|w_busy;
    assign cfgErr   = r_cfgErr;

endmodule
`default_nettype wire

// File: doc/frac_clk_gen.md
FRAC_CLK_GEN -- requirements
Module: frac_clk_gen

Interface
REQ-001 Parameters SHALL be, one per line:
  NUM_CH, 2, number of independent output channels.
  DEN_W, 16, width of ratio numerator/denominator.
  FREQ_IN, 12, reset denominator (input clock MHz).
  FREQ_OUT, 10, reset numerator (target output MHz).
REQ-002 Ports SHALL be, one per line (name  direction  width  meaning):
  clkIn  in  1  sole clock, all logic rising-edge.
  reset  in  1  asynchronous, active-high reset.
  en  in  NUM_CH  per-channel run enable.
  cfgValid  in  1  ratio update request.
  cfgReady  out  1  update slot free.
  cfgCh  in  $clog2(NUM_CH) (min 1)  target channel.
  cfgNum  in  DEN_W  new numerator.
  cfgDen  in  DEN_W  new denominator.
  cfgErr  out  1  one-cycle pulse: update rejected.
  tick  out  NUM_CH  one-cycle clock enable, average rate clkIn*num/den.
  clkOut  out  NUM_CH  square wave toggling on each tick.

Function
REQ-003 Each channel SHALL hold num, den, acc (DEN_W+1 bits) and FSM state IDLE, RUN or PEND.
REQ-004 In RUN/PEND with en=1, per cycle: s=acc+num; if s>=den then acc<=s-den and tick<=1, else acc<=s and tick<=0.
REQ-005 tick SHALL be registered: asserted the cycle after the wrapping accumulation; never two cycles wide unless consecutive wraps.
REQ-006 clkOut SHALL toggle in the same cycle tick is asserted; it holds otherwise.
REQ-007 num==den SHALL give tick every cycle once running; long-run tick count over den*k enabled cycles SHALL equal num*k exactly.
REQ-008 IDLE->RUN when en=1; any state->IDLE when en=0; in IDLE acc<=0, tick<=0, clkOut holds.
REQ-009 A cfg transfer occurs when cfgValid&&cfgReady; cfgReady=1 only when no update is pending in any channel.
REQ-010 Update legality: reject if cfgNum==0, cfgDen==0, cfgNum>cfgDen or cfgCh>=NUM_CH; rejection pulses cfgErr next cycle, state unchanged, cfgReady stays 1.
REQ-011 Accepted update to an IDLE channel SHALL load num/den next cycle, acc<=0; cfgReady returns 1 the cycle after.
REQ-012 Accepted update to a RUN channel SHALL move it to PEND; new num/den and acc<=0 load on the cycle that channel next wraps (that tick still asserted), then RUN, cfgReady<=1.
REQ-013 Transfer coinciding with a wrap on the target channel SHALL defer to the following wrap.
REQ-014 en deasserted in PEND SHALL apply the pending ratio immediately and go IDLE.

Reset
REQ-015 On reset: num=FREQ_OUT, den=FREQ_IN, acc=0, state=IDLE, tick=0, clkOut=0, cfgErr=0, cfgReady=1, pending cleared; asserted mid-operation it SHALL take effect without waiting for a clock edge.
REQ-016 FREQ_OUT>FREQ_IN or FREQ_OUT==0 SHALL fail elaboration.

Structure
REQ-017 Package frac_clk_pkg SHALL hold the state enum and a cfg struct (num, den).
REQ-018 Per-channel accumulator/FSM SHALL be sub-module frac_clk_ch, instantiated NUM_CH times; top holds cfg arbitration.

Verification
REQ-019 Defaults, en[0]=1 for 12 cycles -> tick[0] pattern 0,1,1,1,1,1 repeated, exactly 10 ticks; clkOut[0] toggles 10 times.
REQ-020 cfg ch1 num=1 den=4 while IDLE, then en[1]=1 -> tick[1] every 4th cycle, clkOut[1] period 8 cycles.
REQ-021 cfg ch0 num=3 den=3 while RUN -> cfgReady low until next ch0 wrap, then tick every cycle.
REQ-022 cfgNum=5 cfgDen=4, then cfgNum=0 -> cfgErr pulses each, ratios unchanged.
REQ-023 reset asserted mid-run between edges -> tick=0, clkOut=0 immediately; post-release 12/10 pattern restarts from acc=0.
REQ-024 en[0] dropped while PEND -> IDLE next cycle, new ratio in effect on re-enable.
